// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: small register-file memory cleared by a sweep,
// side load port, valid/ready fetch channel with a registered response.
module inst_mem_responder #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 2,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              clr,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              accept;
    logic              consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = 1'b1;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLEAR_VAL;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST) begin
                    state_d = READY;
                end
            end
            READY: begin
                busy      = 1'b0;
                req_ready = !rsp_valid || rsp_ready;
                mem_we    = ld_en;
                mem_waddr = ld_addr;
                mem_wdata = ld_data;
                // a load in the same cycle still lands; the sweep then overwrites it
                if (clr) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
        endcase
    end

    assign accept  = req_valid && req_ready;
    assign consume = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem[req_addr];
        end else if (consume) begin
            rsp_valid <= 1'b0;
        end
    end

    // read above sees the pre-write word, giving read-before-write on collisions
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: directed vector table, reset corner case,
// then random traffic against a cycle-level behavioural model.
module tb_inst_mem_responder;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam logic [7:0] CV = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0] req_addr, ld_addr;
    logic [7:0] rsp_data, ld_data;
    logic       ld_en, clr, busy;

    always #5 clk = ~clk;

    inst_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_VAL(CV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .clr(clr), .busy(busy)
    );

    typedef struct {
        logic       clr;
        logic       ld_en;
        logic [1:0] ld_addr;
        logic [7:0] ld_data;
        logic       req_valid;
        logic [1:0] req_addr;
        logic       rsp_ready;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       e_rr;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // model: sweep cycles left, memory image, one response slot
    logic [7:0] m_mem [DEPTH];
    int         m_left;
    logic       m_rv;
    logic [7:0] m_rd;

    function automatic vec_t mk(
        logic c, logic le, logic [1:0] la, logic [7:0] ld,
        logic rqv, logic [1:0] ra, logic rsr,
        logic erv, logic [7:0] erd, logic err, logic eb);
        vec_t v;
        v.clr = c; v.ld_en = le; v.ld_addr = la; v.ld_data = ld;
        v.req_valid = rqv; v.req_addr = ra; v.rsp_ready = rsr;
        v.e_rv = erv; v.e_rd = erd; v.e_rr = err; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic model_reset();
        m_left = DEPTH;
        m_rv   = 1'b0;
        m_rd   = 8'h00;
    endtask

    task automatic model_step();
        logic       rdy;
        logic [7:0] rd;
        rdy = (m_left == 0) && (!m_rv || rsp_ready);
        rd  = m_mem[req_addr];
        if (m_left != 0) begin
            m_mem[DEPTH - m_left] = CV;
            m_left--;
        end else begin
            if (ld_en) m_mem[ld_addr] = ld_data;
            if (clr) m_left = DEPTH;
        end
        if (req_valid && rdy) begin
            m_rv = 1'b1;
            m_rd = rd;
        end else if (rsp_ready) begin
            m_rv = 1'b0;
        end
    endtask

    task automatic next_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        clr = v.clr; ld_en = v.ld_en; ld_addr = v.ld_addr;
        ld_data = v.ld_data; req_valid = v.req_valid;
        req_addr = v.req_addr; rsp_ready = v.rsp_ready;
    endtask

    task automatic chk_model(input string n);
        chk({n, "_rv"}, rsp_valid, m_rv);
        chk({n, "_rd"}, rsp_data, m_rd);
        chk({n, "_busy"}, busy, m_left != 0);
        chk({n, "_rr"}, req_ready,
            (m_left == 0) && (!m_rv || rsp_ready));
    endtask

    initial begin
        clr = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
        req_valid = 0; req_addr = 0; rsp_ready = 0;
        model_reset();

        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,8'h00, 1,0,0, 0,8'h00,0,1));
        vecs.push_back(mk(0,0,0,8'h00, 1,0,0, 0,8'h00,1,0));
        vecs.push_back(mk(0,1,0,8'hA0, 0,0,1, 1,8'h00,1,0));
        vecs.push_back(mk(0,1,1,8'hA1, 0,0,1, 0,8'h00,1,0));
        vecs.push_back(mk(0,1,2,8'hA2, 0,0,1, 0,8'h00,1,0));
        vecs.push_back(mk(0,1,3,8'hA3, 0,0,1, 0,8'h00,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,0,1, 0,8'h00,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,1,1, 1,8'hA0,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,2,1, 1,8'hA1,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,3,1, 1,8'hA2,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,0,1, 1,8'hA3,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,2,1, 1,8'hA0,1,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,8'h00, 1,3,0, 1,8'hA2,0,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,3,1, 1,8'hA2,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 1,8'hA3,1,0));
        vecs.push_back(mk(0,1,1,8'h5C, 1,1,1, 0,8'hA3,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,1,1, 1,8'hA1,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,0,1, 1,8'h5C,1,0));
        vecs.push_back(mk(1,0,0,8'h00, 0,0,0, 1,8'hA0,0,0));
        vecs.push_back(mk(0,1,2,8'h77, 1,1,0, 1,8'hA0,0,1));
        vecs.push_back(mk(0,1,3,8'h88, 1,1,0, 1,8'hA0,0,1));
        vecs.push_back(mk(0,1,2,8'h99, 1,1,1, 1,8'hA0,0,1));
        vecs.push_back(mk(0,0,0,8'h00, 1,1,1, 0,8'hA0,0,1));
        vecs.push_back(mk(0,0,0,8'h00, 1,0,1, 0,8'hA0,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,1,1, 1,8'h00,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,2,1, 1,8'h00,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 1,3,1, 1,8'h00,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 1,8'h00,1,0));
        vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 0,8'h00,1,0));

        #2;
        chk("rst_rv", rsp_valid, 0);
        chk("rst_rd", rsp_data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_rr", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_rv", i), rsp_valid, vecs[i].e_rv);
            chk($sformatf("v%0d_rd", i), rsp_data, vecs[i].e_rd);
            chk($sformatf("v%0d_rr", i), req_ready, vecs[i].e_rr);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            next_cycle();
        end

        // asynchronous reset with a response pending
        apply(mk(0,0,0,8'h00, 1,2,0, 0,8'h00,0,0));
        @(negedge clk);
        next_cycle();
        #2;
        chk("prerst_rv", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rv", rsp_valid, 0);
        chk("midrst_rd", rsp_data, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_rr", req_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("sweep%0d_busy", i), busy, 1);
            chk($sformatf("sweep%0d_rr", i), req_ready, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("postsweep_busy", busy, 0);
        chk("postsweep_rr", req_ready, 1);
        next_cycle();
        @(negedge clk);
        chk("postsweep_rv", rsp_valid, 1);
        chk("postsweep_rd", rsp_data, CV);
        next_cycle();

        for (int i = 0; i < 600; i++) begin
            clr       = ($urandom_range(0, 19) == 0);
            ld_en     = ($urandom_range(0, 2) == 0);
            ld_addr   = 2'($urandom);
            ld_data   = 8'($urandom);
            req_valid = ($urandom_range(0, 1) == 1);
            req_addr  = 2'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            chk_model($sformatf("rnd%0d", i));
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
